// File: rtl/match_filter.sv
// Match filter: ratio-test gating of match words, per-frame summary, show-ahead FIFO.
// Optional absolute-distance gate: define MATCH_FILTER_ABSDIST_EN.
module match_filter #(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int NUM_BITS               = 8,
   parameter int RATIO                  = 2,
   parameter int FIFO_DEPTH             = 16,
   parameter int MAX_DIST               = 2
) (
   input  logic                                  s00_axis_aclk,
   input  logic                                  s00_axis_areset,
   input  logic                                  s00_axis_tvalid,
   input  logic                                  s00_axis_tlast,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
   output logic                                  s00_axis_tready,
   input  logic                                  m00_axis_tready,
   output logic                                  m00_axis_tvalid,
   output logic                                  m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb
);
   localparam int KEY_SIZE = $clog2(NUM_BITS) + 1;
   localparam int PW       = KEY_SIZE + $clog2(RATIO) + 1;
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int DW       = C_M00_AXIS_TDATA_WIDTH;

   typedef enum logic {RUN, SUMMARY} state_t;

   state_t          state_q, state_d;
   logic [DW:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [7:0]      tot_q, tot_d, acc_q, acc_d;
   logic            wr_en;
   logic [DW:0]     wr_word;
   logic            full, empty, in_fire, rd_fire, pass;
   logic [PW-1:0]   d1, d2, prod;
   logic            unused_in;

   assign unused_in = ^{s00_axis_tstrb,
                        s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:24]};

   assign full  = cnt_q == (AW+1)'(FIFO_DEPTH);
   assign empty = cnt_q == '0;

   assign s00_axis_tready = !s00_axis_areset && state_q == RUN && !full;
   assign m00_axis_tvalid = !s00_axis_areset && !empty;
   assign {m00_axis_tlast, m00_axis_tdata} = mem_q[rptr_q];
   assign m00_axis_tstrb  = '1;

   assign in_fire = s00_axis_tvalid && s00_axis_tready;
   assign rd_fire = m00_axis_tvalid && m00_axis_tready;

   // Widened so dist1*RATIO cannot wrap before the compare.
   assign d1   = PW'(s00_axis_tdata[23:20]);
   assign d2   = PW'(s00_axis_tdata[19:16]);
   assign prod = d1 * PW'(RATIO);

   always_comb begin
      pass = (d1 != PW'(NUM_BITS)) && (prod < d2);
`ifdef MATCH_FILTER_ABSDIST_EN
      pass = pass && (d1 <= PW'(MAX_DIST));
`endif
   end

`ifndef MATCH_FILTER_ABSDIST_EN
   localparam int unused_max_dist = MAX_DIST;
`endif

   always_comb begin
      state_d = state_q;
      tot_d   = tot_q;
      acc_d   = acc_q;
      wr_en   = 1'b0;
      wr_word = '0;
      unique case (state_q)
         RUN: begin
            wr_word[23:0] = s00_axis_tdata[23:0];
            if (in_fire) begin
               wr_en = pass;
               if (tot_q != 8'hff) tot_d = tot_q + 8'd1;
               if (pass && acc_q != 8'hff) acc_d = acc_q + 8'd1;
               if (s00_axis_tlast) state_d = SUMMARY;
            end
         end
         SUMMARY: begin
            wr_word[DW]   = 1'b1;
            wr_word[31]   = 1'b1;
            wr_word[15:8] = acc_q;
            wr_word[7:0]  = tot_q;
            if (!full) begin
               wr_en   = 1'b1;
               tot_d   = '0;
               acc_d   = '0;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      wptr_d = wptr_q + AW'(wr_en);
      rptr_d = rptr_q + AW'(rd_fire);
      cnt_d  = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_fire);
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         state_q <= RUN;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         tot_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         tot_q   <= tot_d;
         acc_q   <= acc_d;
      end
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (wr_en) mem_q[wptr_q] <= wr_word;
   end
endmodule

// File: tb/tb_match_filter.sv
// Bench for match_filter: directed frames plus randomized traffic
// against a queue-based reference model.
module tb_match_filter;
   localparam int MAX_DIST = 1;
   localparam int NUM_BITS = 8;
   localparam int RATIO    = 2;

   logic        clk = 1'b0;
   logic        areset;
   logic        s_tvalid, s_tlast, s_tready;
   logic [31:0] s_tdata;
   logic [3:0]  s_tstrb;
   logic        m_tready, m_tvalid, m_tlast;
   logic [31:0] m_tdata;
   logic [3:0]  m_tstrb;

   int n_chk  = 0;
   int n_pass = 0;
   int rmode  = 0;
   int m_tot  = 0;
   int m_acc  = 0;
   logic [32:0] expq [$];
   logic [32:0] obs  [$];
   logic [32:0] e    [$];

   always #5 clk = ~clk;

   match_filter #(
      .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32),
      .NUM_BITS(NUM_BITS), .RATIO(RATIO), .FIFO_DEPTH(16),
      .MAX_DIST(MAX_DIST)
   ) dut (
      .s00_axis_aclk(clk), .s00_axis_areset(areset),
      .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
      .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb),
      .s00_axis_tready(s_tready), .m00_axis_tready(m_tready),
      .m00_axis_tvalid(m_tvalid), .m00_axis_tlast(m_tlast),
      .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic model_beat(input logic [31:0] d, input logic l);
      int a, b;
      bit ok;
      a  = int'(d[23:20]);
      b  = int'(d[19:16]);
      ok = (a != NUM_BITS) && (a * RATIO < b);
`ifdef MATCH_FILTER_ABSDIST_EN
      ok = ok && (a <= MAX_DIST);
`endif
      if (ok) expq.push_back({1'b0, 8'h00, d[23:0]});
      m_tot = (m_tot < 255) ? m_tot + 1 : 255;
      if (ok) m_acc = (m_acc < 255) ? m_acc + 1 : 255;
      if (l) begin
         expq.push_back({1'b1, 16'h8000, 8'(m_acc), 8'(m_tot)});
         m_tot = 0;
         m_acc = 0;
      end
   endtask

   task automatic send(input logic [31:0] d, input logic l);
      int n = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      forever begin
         @(negedge clk);
         if (s_tready) break;
         n++;
         if (n > 2000) begin
            chk("tready_timeout", 0, 1);
            s_tvalid = 1'b0;
            sync();
            return;
         end
      end
      model_beat(d, l);
      sync();
      s_tvalid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (expq.size() == 0 && !m_tvalid) break;
      end
      chk("drain_empty", expq.size(), 0);
      sync();
   endtask

   task automatic do_reset();
      areset = 1'b1;
      expq.delete();
      m_tot = 0;
      m_acc = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_tstrb", m_tstrb, 4'hf);
      sync();
      areset = 1'b0;
      @(negedge clk);
      chk("post_rst_s_tready", s_tready, 1);
      chk("post_rst_m_tvalid", m_tvalid, 0);
      sync();
   endtask

   task automatic expect_obs(input string tag, input logic [32:0] ex[$]);
      chk({tag, "_count"}, obs.size(), ex.size());
      for (int i = 0; i < ex.size() && i < obs.size(); i++)
         chk(tag, obs[i], ex[i]);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_tready = (rmode == 1) ? 1'b1 :
                    (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   initial begin
      logic [32:0] prev_w;
      logic [32:0] got;
      bit stall_prev = 0;
      forever begin
         @(negedge clk);
         got = {m_tlast, m_tdata};
         if (m_tvalid && stall_prev) chk("hold_stable", got, prev_w);
         stall_prev = m_tvalid && !m_tready;
         prev_w     = got;
         if (m_tvalid && m_tready) begin
            if (expq.size() == 0) chk("unexpected_out", got, ~got);
            else chk("out_order", got, expq.pop_front());
            obs.push_back(got);
         end
      end
   end

   initial begin
      logic [31:0] d;
      logic        l;
      areset   = 1'b1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = '0;
      s_tstrb  = '0;
      m_tready = 1'b0;
      sync();
      do_reset();

      rmode = 1;
      obs.delete();
      send(32'h0013_8A55, 0);
      send(32'h0024_1122, 0);
      send(32'h0008_3344, 1);
      drain();
      e = '{33'h0_0013_8A55, 33'h0_0008_3344, 33'h1_8000_0203};
      expect_obs("frame3", e);

      obs.delete();
      send(32'h0088_0000, 1);
      drain();
      e = '{33'h1_8000_0001};
      expect_obs("dist_nb", e);

      rmode = 0;
      obs.delete();
      e.delete();
      for (int i = 0; i < 16; i++) begin
         send(32'h0008_0000 | 32'(i), 0);
         e.push_back(33'h0_0008_0000 | 33'(i));
      end
      @(negedge clk);
      chk("full_s_tready", s_tready, 0);
      chk("full_m_tvalid", m_tvalid, 1);
      sync();
      rmode = 1;
      for (int i = 16; i < 20; i++) begin
         send(32'h0008_0000 | 32'(i), i == 19);
         e.push_back(33'h0_0008_0000 | 33'(i));
      end
      e.push_back(33'h1_8000_1414);
      drain();
      expect_obs("backpressure", e);

      rmode = 0;
      for (int i = 0; i < 3; i++) send(32'h0013_8A55, 0);
      do_reset();
      rmode = 1;
      obs.delete();
      send(32'h0018_0102, 1);
      drain();
      e = '{33'h0_0018_0102, 33'h1_8000_0101};
      expect_obs("mid_reset", e);

      obs.delete();
      send(32'h0028_0102, 1);
      drain();
`ifdef MATCH_FILTER_ABSDIST_EN
      e = '{33'h1_8000_0001};
`else
      e = '{33'h0_0028_0102, 33'h1_8000_0101};
`endif
      expect_obs("absdist", e);

      rmode = 2;
      obs.delete();
      for (int i = 0; i < 260; i++) send(32'h0008_0000, i == 259);
      drain();
      chk("sat_count", obs.size(), 261);
      if (obs.size() > 0) chk("sat_summary", obs[obs.size()-1], 33'h1_8000_FFFF);

      for (int i = 0; i < 400; i++) begin
         d        = $urandom;
         d[23:20] = 4'($urandom_range(0, 9));
         l        = ($urandom_range(0, 15) == 0) || (i == 399);
         send(d, l);
         if ($urandom_range(0, 3) == 0) sync();
         if (i == 200) do_reset();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/match_filter.md
MATCH_FILTER -- requirements
Module: match_filter

Interface
REQ-001 SHALL have parameter C_S00_AXIS_TDATA_WIDTH, default 32: input stream width.
REQ-002 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 32: output stream width.
REQ-003 SHALL have parameter NUM_BITS, default 8: descriptor width; KEY_SIZE = clog2(NUM_BITS)+1.
REQ-004 SHALL have parameter RATIO, default 2: ratio-test multiplier.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: output buffer entries, power of two.
REQ-006 SHALL have parameter MAX_DIST, default 2: absolute distance limit, used only under REQ-030.
REQ-007 SHALL have ports:
  s00_axis_aclk  in  1  sole clock, rising edge
  s00_axis_areset  in  1  synchronous, active-high reset
  s00_axis_tvalid  in  1  match word valid
  s00_axis_tlast  in  1  last match word of frame
  s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  match word
  s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored
  s00_axis_tready  out  1  input accept
  m00_axis_tready  in  1  downstream accept
  m00_axis_tvalid  out  1  output valid
  m00_axis_tlast  out  1  end of output frame
  m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  filtered word
  m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  constant all ones

Function
REQ-008 Input word fields SHALL be dist1=[23:20], dist2=[19:16], a=[15:8], b=[7:0]; bits [31:24] ignored.
REQ-009 Beat transfer SHALL occur on a rising edge with s00_axis_tvalid && s00_axis_tready; same rule for output.
REQ-010 A beat SHALL be accepted iff dist1 != NUM_BITS and dist1*RATIO < dist2, computed without overflow (width KEY_SIZE+clog2(RATIO)+1).
REQ-011 Accepted beat SHALL be written to FIFO as tdata {8'h00, in[23:0]}, tlast 0; rejected beat SHALL be dropped.
REQ-012 Per frame, 8-bit counters total and accepted SHALL count transferred and accepted beats, saturating at 255.
REQ-013 After a tlast beat, next FIFO write SHALL be summary word: [31]=1, [30:16]=0, [15:8]=accepted, [7:0]=total, tlast 1; counts include the tlast beat.
REQ-014 Counters SHALL clear in the cycle the summary word is written.
REQ-015 FSM SHALL have states RUN and SUMMARY: RUN->SUMMARY on tlast beat; SUMMARY->RUN when summary written (FIFO not full).
REQ-016 s00_axis_tready SHALL be 1 only in RUN with FIFO not full (registered count, no same-cycle read credit).
REQ-017 FIFO SHALL be show-ahead: m00_axis_tvalid = FIFO non-empty; tdata/tlast = head entry.
REQ-018 Latency: accepted beat on edge N into empty FIFO SHALL appear on m00 after edge N.
REQ-019 Simultaneous FIFO read and write SHALL keep count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-020 Output order SHALL equal input order; no beat SHALL be lost or duplicated under any backpressure.
REQ-021 A frame with zero accepted beats SHALL yield only its summary word.
REQ-022 m00_axis_tdata/tlast SHALL stay stable while m00_axis_tvalid && !m00_axis_tready.

Reset
REQ-023 With s00_axis_areset=1 at an edge: FIFO empty, pointers 0, counters 0, FSM RUN.
REQ-024 During/after reset: m00_axis_tvalid=0, s00_axis_tready=0 while reset is asserted, m00_axis_tstrb all ones.
REQ-025 Reset mid-frame SHALL discard the partial frame and buffered words; no summary for it.

Configuration
REQ-030 With macro MATCH_FILTER_ABSDIST_EN defined, acceptance SHALL additionally require dist1 <= MAX_DIST.
REQ-031 Without MATCH_FILTER_ABSDIST_EN, MAX_DIST SHALL have no effect; REQ-010 alone decides.

Verification
REQ-040 Frame 0x0013_8A55, 0x0024_1122, 0x0008_3344(tlast), tready=1 -> out 0x0013_8A55, 0x0008_3344, 0x8000_0203(tlast).
REQ-041 Single beat 0x0088_0000 with tlast -> only 0x8000_0001 tlast 1.
REQ-042 m00_axis_tready=0, 20 accepted beats, last tlast -> s00_axis_tready drops after 16 writes; release -> all 20 plus summary 0x8000_1414, in order.
REQ-043 Reset after 3 of 5 beats, then new frame 0x0018_0102(tlast) -> only 0x0018_0102, 0x8000_0101.
REQ-044 Beat 0x0028_0102 tlast: without MATCH_FILTER_ABSDIST_EN -> passed plus 0x8000_0101; with it (MAX_DIST=1) -> only 0x8000_0001.
